// File: rtl/loa_add_arbiter_pkg.sv
// ============================================================================
// Module      : loa_add_arbiter_pkg
// Description : Shared widths, output-register state and round-robin pick
//               function for the LOA adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loa_add_arbiter_pkg;

    localparam int ADD_W       = 16;
    localparam int RES_W       = 17;
    localparam int LOWER_W_DEF = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Returns {found, index}. The search begins at 'start' and wraps modulo n,
    // so the lowest index at or after 'start' that is requesting wins.
    function automatic logic [3:0] rr_pick(input logic [7:0]  req,
                                           input logic [2:0]  start,
                                           input int unsigned n);
        logic [3:0]  res;
        logic        found;
        int unsigned idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && (i < n)) begin
                idx = (32'(start) + i) % n;
                if (req[idx[2:0]]) begin
                    found = 1'b1;
                    res   = {1'b1, idx[2:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/loa_adder_core.sv
// ============================================================================
// Module      : loa_adder_core
// Description : Combinational 16-bit adder with exact or lower-part-OR mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loa_adder_core
    import loa_add_arbiter_pkg::*;
#(
    parameter int LOWER_W = LOWER_W_DEF
) (
    input  logic [ADD_W-1:0] i_a,
    input  logic [ADD_W-1:0] i_b,
    input  logic             i_approx,
    output logic [RES_W-1:0] o_sum
);

    localparam int HI_W = RES_W - LOWER_W;

    logic [HI_W-1:0]    w_hi;
    logic [LOWER_W-1:0] w_lo;
    logic [RES_W-1:0]   w_exact;

    // The top bit of the OR'd region still feeds a carry into the exact upper part.
    assign w_hi    = HI_W'(i_a[ADD_W-1:LOWER_W]) + HI_W'(i_b[ADD_W-1:LOWER_W])
                   + HI_W'(i_a[LOWER_W-1] & i_b[LOWER_W-1]);
    assign w_lo    = i_a[LOWER_W-1:0] | i_b[LOWER_W-1:0];
    assign w_exact = RES_W'(i_a) + RES_W'(i_b);
    assign o_sum   = i_approx ? {w_hi, w_lo} : w_exact;

endmodule

`default_nettype wire

// File: rtl/loa_add_arbiter.sv
// ============================================================================
// Module      : loa_add_arbiter
// Description : Round-robin arbiter feeding one shared LOA adder into a
//               single-entry registered output with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loa_add_arbiter
    import loa_add_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LOWER_W = LOWER_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*ADD_W-1:0] add1_i,
    input  logic [N_REQ*ADD_W-1:0] add2_i,
    input  logic [N_REQ-1:0]       approx_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic [RES_W-1:0]       result_o,
    output logic [2:0]             id_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    state_t             r_state;
    logic [2:0]         r_ptr;
    logic [RES_W-1:0]   r_result;
    logic [2:0]         r_id;

    logic [7:0]         w_req8;
    logic [3:0]         w_pick;
    logic [2:0]         w_win;
    logic               w_grant;
    logic [ADD_W-1:0]   w_a;
    logic [ADD_W-1:0]   w_b;
    logic               w_approx;
    logic [RES_W-1:0]   w_sum;

    always_comb begin
        w_req8             = '0;
        w_req8[N_REQ-1:0]  = req_i;
    end

    assign w_pick  = rr_pick(w_req8, r_ptr, N_REQ);
    assign w_win   = w_pick[2:0];
    // A full register may only be refilled in the same cycle it is drained.
    assign w_grant = !rst_i && w_pick[3] && ((r_state == EMPTY) || ready_i);

    always_comb begin
        ack_o = '0;
        if (w_grant) begin
            ack_o[w_win] = 1'b1;
        end
    end

    assign w_a      = add1_i[int'(w_win)*ADD_W +: ADD_W];
    assign w_b      = add2_i[int'(w_win)*ADD_W +: ADD_W];
    assign w_approx = approx_i[w_win];

    loa_adder_core #(
        .LOWER_W (LOWER_W)
    ) u_core (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_approx (w_approx),
        .o_sum    (w_sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= EMPTY;
            r_ptr    <= 3'd0;
            r_result <= '0;
            r_id     <= 3'd0;
        end else if (w_grant) begin
            r_state  <= FULL;
            r_result <= w_sum;
            r_id     <= w_win;
            r_ptr    <= (w_win == 3'(N_REQ - 1)) ? 3'd0 : w_win + 3'd1;
        end else if ((r_state == FULL) && ready_i) begin
            r_state  <= EMPTY;
        end
    end

    assign result_o = r_result;
    assign id_o     = r_id;
    assign valid_o  = (r_state == FULL);

endmodule

`default_nettype wire

// File: tb/tb_loa_add_arbiter.sv
// ============================================================================
// Module      : tb_loa_add_arbiter
// Description : Directed and random scoreboard bench for loa_add_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loa_add_arbiter;
    import loa_add_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*16-1:0]  add1;
    logic [NR*16-1:0]  add2;
    logic [NR-1:0]     apx;
    logic [NR-1:0]     ack;
    logic [16:0]       result;
    logic [2:0]        id;
    logic              valid;
    logic              ready;

    logic [15:0]       opa [NR];
    logic [15:0]       opb [NR];
    logic              opx [NR];

    int                checks = 0;
    int                errors = 0;
    logic [19:0]       q [$];
    logic              exp_full = 1'b0;
    logic [2:0]        exp_ptr  = 3'd0;
    logic [NR-1:0]     last_ack;
    int                wait_cnt [NR];
    logic [16:0]       held;

    loa_add_arbiter #(.N_REQ(NR), .LOWER_W(LW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .add1_i   (add1),
        .add2_i   (add2),
        .approx_i (apx),
        .ack_o    (ack),
        .result_o (result),
        .id_o     (id),
        .valid_o  (valid),
        .ready_i  (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic x);
        int unsigned lo, hi, c;
        if (!x) return 17'(32'(a) + 32'(b));
        lo = (32'(a) | 32'(b)) & ((1 << LW) - 1);
        c  = ((32'(a) >> (LW - 1)) & (32'(b) >> (LW - 1))) & 1;
        hi = (32'(a) >> LW) + (32'(b) >> LW) + c;
        return 17'((hi << LW) | lo);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            add1[k*16 +: 16] = opa[k];
            add2[k*16 +: 16] = opb[k];
            apx[k]           = opx[k];
        end
    endtask

    // Compare at the falling edge, then advance the model to the next rising edge.
    task automatic step();
        logic [3:0] pk;
        logic       g;
        logic       pop;
        int         w;
        @(negedge clk);
        pk  = rr_pick(8'(req), exp_ptr, NR);
        w   = int'(pk[2:0]);
        g   = !rst && pk[3] && (!exp_full || ready);
        pop = exp_full && ready;
        check("ack", 32'(ack), g ? (32'd1 << w) : 32'd0);
        check("ack_subset", 32'(ack & ~req), 32'd0);
        check("valid", 32'(valid), 32'(exp_full));
        if (exp_full && q.size() > 0) check("data", {12'd0, id, result}, 32'(q[0]));
        last_ack = ack;
        if (rst) begin
            q.delete();
            exp_full = 1'b0;
            exp_ptr  = 3'd0;
            for (int k = 0; k < NR; k++) wait_cnt[k] = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (g) begin
                q.push_back({3'(w), ref_sum(opa[w], opb[w], opx[w])});
                exp_ptr = (w == NR - 1) ? 3'd0 : 3'(w + 1);
                for (int k = 0; k < NR; k++) begin
                    if (k == w || !req[k]) begin
                        wait_cnt[k] = 0;
                    end else begin
                        wait_cnt[k]++;
                        check("starve", 32'(wait_cnt[k] <= NR - 1), 32'd1);
                    end
                end
            end
            exp_full = g ? 1'b1 : (pop ? 1'b0 : exp_full);
        end
        @(posedge clk);
        #1;
    endtask

    logic [15:0] va [6] = '{16'h000F, 16'h000F, 16'h0008, 16'h0008, 16'hFFFF, 16'hFFFF};
    logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h0008, 16'h0008, 16'hFFFF, 16'hFFFF};
    logic        vx [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [16:0] vr [6] = '{17'h0000F, 17'h00010, 17'h00018, 17'h00010, 17'h1FFFF, 17'h1FFFE};
    logic [3:0]  fair [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0]  fid  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    initial begin
        for (int k = 0; k < NR; k++) begin
            opa[k] = 16'(k + 1); opb[k] = 16'(k * 3); opx[k] = 1'b0; wait_cnt[k] = 0;
        end
        drive();
        rst = 1'b1; req = 4'b1111; ready = 1'b1;
        @(posedge clk); #1;

        // Reset state; ack must stay low while reset is held.
        step();
        check("rst_ack", 32'(last_ack), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_id", 32'(id), 32'd0);

        // Arithmetic vectors on requester 0, back to back.
        rst = 1'b0; req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            opa[0] = va[i]; opb[0] = vb[i]; opx[0] = vx[i]; drive();
            step();
            check("arith", 32'(result), 32'(vr[i]));
            check("arith_ack", 32'(last_ack), 32'd1);
        end
        check("ovf_msb", 32'(result[16]), 32'd1);

        // Fairness from a fresh reset.
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("fair_ack", 32'(last_ack), 32'(fair[i]));
            check("fair_id", 32'(id), 32'(fid[i]));
        end

        // Backpressure while full.
        req = 4'b0011; ready = 1'b0; held = result;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ack", 32'(last_ack), 32'd0);
            check("bp_hold", 32'(result), 32'(held));
            check("bp_valid", 32'(valid), 32'd1);
        end
        ready = 1'b1;
        step();
        check("bp_release_ack", 32'(last_ack), 32'b0010);
        check("bp_release_valid", 32'(valid), 32'd1);
        check("bp_release_id", 32'(id), 32'd1);

        // Reset while full discards the pending result.
        rst = 1'b1; step();
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        rst = 1'b0; req = 4'b1111;
        step();
        check("mid_rst_ack", 32'(last_ack), 32'b0001);

        // Random regression: requests persist with stable operands until acked.
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (!(req[k] && !last_ack[k])) begin
                    req[k] = 1'($urandom_range(0, 1));
                    opa[k] = 16'($urandom);
                    opb[k] = 16'($urandom);
                    opx[k] = 1'($urandom_range(0, 1));
                end
            end
            ready = ($urandom_range(0, 3) != 0);
            drive();
            step();
        end

        req = 4'b0000; ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/loa_add_arbiter.md
LOA_ADD_ARBITER -- requirements
Module: loa_add_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter: LOWER_W, default 4, width of the OR-approximated lower part (1..15).
REQ-003 Port: clk_i  in  1  single clock, rising edge.
REQ-004 Port: rst_i  in  1  reset; synchronous, active-high.
REQ-005 Port: req_i  in  N_REQ  per-requester request; held high with operands stable until acked.
REQ-006 Port: add1_i  in  N_REQ*16  packed operand A; slice k belongs to requester k.
REQ-007 Port: add2_i  in  N_REQ*16  packed operand B, same packing.
REQ-008 Port: approx_i  in  N_REQ  per-requester mode; 1 = lower-part-OR, 0 = exact.
REQ-009 Port: ack_o  out  N_REQ  one-hot, one-cycle grant pulse.
REQ-010 Port: result_o  out  17  registered sum.
REQ-011 Port: id_o  out  3  index of the requester that owns result_o.
REQ-012 Port: valid_o  out  1  result_o and id_o are valid.
REQ-013 Port: ready_i  in  1  downstream accepts the result when valid_o and ready_i are both high.

Function
REQ-014 Approximate mode shall compute:
  - result_o[LOWER_W-1:0] = A|B on those bits.
  - result_o[16:LOWER_W] = A[15:LOWER_W] + B[15:LOWER_W] + (A[LOWER_W-1] & B[LOWER_W-1]).
REQ-015 Exact mode shall compute result_o = A + B, zero-extended to 17 bits.
REQ-016 The block shall hold a single output register with states EMPTY and FULL; valid_o = FULL.
REQ-017 A grant shall occur in a cycle where any req_i bit is high and the state is EMPTY, or FULL with ready_i high.
REQ-018 On a grant:
  - ack_o pulses for exactly the winner in that cycle.
  - The winner's result, id and mode-selected sum are registered at the next edge.
  - valid_o is high from the next cycle (latency 1).
REQ-019 On a simultaneous pop and grant, the state shall stay FULL, the new data shall replace the old, and no bubble cycle shall occur.
REQ-020 On a pop with no grant, the state shall go to EMPTY.
REQ-021 While FULL and ready_i is low, result_o, id_o and valid_o shall hold and ack_o shall be 0.
REQ-022 Arbitration shall be round-robin:
  - Search starts at (last winner + 1) mod N_REQ.
  - After reset, requester 0 has highest priority.
  - The pointer updates only on a grant.
REQ-023 With a single active requester, back-to-back grants shall be issued every cycle while ready_i is high.
REQ-024 ack_o shall never have more than one bit set, and shall never assert a bit whose req_i is low.
REQ-025 The mode shall be sampled from approx_i of the winner in the grant cycle.

Reset
REQ-026 While rst_i is high at an edge:
  - state = EMPTY, valid_o = 0, result_o = 0, id_o = 0, RR pointer = requester 0.
  - ack_o = 0 combinationally while rst_i is high.
REQ-027 A reset asserted while FULL shall discard the pending result without a handshake.

Structure
REQ-028 A shared package shall hold ADD_W = 16, RES_W = 17, the default LOWER_W and the state enumeration {EMPTY, FULL}.
REQ-029 The datapath shall be one combinational sub-module, loa_adder_core, parameterised by LOWER_W with an exact/approx select, instantiated once after the grant mux.
REQ-030 The round-robin pick shall be a function in the same package so the bench reuses it as a reference model.

Verification
REQ-031 Approx arithmetic, LOWER_W=4, single requester:
  - A=0x000F, B=0x0001, approx=1 -> result_o=0x0000F; approx=0 -> 0x00010.
  - A=0x0008, B=0x0008, approx=1 -> 0x00018; exact -> 0x00010.
REQ-032 Overflow: A=0xFFFF, B=0xFFFF -> approx 0x1FFFF, exact 0x1FFFE, with result_o[16]=1 in both.
REQ-033 Fairness:
  - Stimulus: all 4 req_i high continuously, ready_i=1.
  - Response: ack_o sequence 0001, 0010, 0100, 1000, 0001; id_o follows one cycle later.
REQ-034 Backpressure:
  - Stimulus: ready_i=0 for 5 cycles while FULL with req_i=0011.
  - Response: ack_o=0 and outputs held; on ready_i=1, pop and new grant occur in the same cycle with no bubble.
REQ-035 Reset mid-operation:
  - Stimulus: rst_i pulsed while FULL.
  - Response: next cycle valid_o=0, result_o=0, and the next grant with req_i=1111 goes to requester 0.
REQ-036 Random regression: 10k cycles of random req_i, ready_i and operands against the package model, with zero mismatches, no lost or duplicated ack, and no starvation beyond N_REQ-1 grants.
